// File: rtl/add_round_key_stage_if.sv
// Valid/ready, key-load and result bundle for the AddRoundKey stage.
// The stage binds the slave modport; the upstream controller binds master.
interface add_round_key_stage_if #(
  parameter int W = 128
);
  logic          key_we;
  logic [3:0]    key_addr;
  logic [W-1:0]  key_wdata;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_first;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [3:0]    out_round;
  logic          out_last;

  modport master (
    output key_we, key_addr, key_wdata,
    output in_valid, in_data, in_first,
    input  in_ready,
    input  out_valid, out_data, out_round, out_last,
    output out_ready
  );

  modport slave (
    input  key_we, key_addr, key_wdata,
    input  in_valid, in_data, in_first,
    output in_ready,
    output out_valid, out_data, out_round, out_last,
    input  out_ready
  );
endinterface

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey: XORs each state beat with key[round] from an internal
// key file, tracks the round per block and offers one-entry valid/ready buffering.
module add_round_key_stage #(
  parameter int NR = 10,
  parameter int W  = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add_round_key_stage_if.slave bus
);

  if (NR > 15 || NR < 1) begin : g_nr_check
    $error("add_round_key_stage: NR must be in 1..15");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  logic [W-1:0] key_q [NR+1];
  logic [3:0]   rnd_q, rnd_d;

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic [3:0]   out_round_q;
  logic         out_last_q;

  logic         in_ready;
  logic         accept;
  logic [3:0]   r;
  logic [W-1:0] key_sel;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    r       = bus.in_first ? 4'd0 : rnd_q;
    rnd_d   = (r == NR_L) ? 4'd0 : r + 4'd1;
    key_sel = '0;
    // Explicit mux keeps the 4-bit index from reaching past the NR+1 entries.
    for (int unsigned i = 0; i <= NR; i++) begin
      if (r == 4'(i)) key_sel = key_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= NR; i++) key_q[i] <= '0;
    end else begin
      // Addresses above NR match no entry and are dropped.
      for (int unsigned i = 0; i <= NR; i++) begin
        if (bus.key_we && bus.key_addr == 4'(i)) key_q[i] <= bus.key_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      rnd_q       <= rnd_d;
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data ^ key_sel;
      out_round_q <= r;
      out_last_q  <= (r == NR_L);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_round = out_round_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage: a round/key model predicts every
// output beat at acceptance; outputs are checked 1 time unit after each negedge.
module tb_add_round_key_stage;

  localparam int NR = 10;
  localparam int W  = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_round_key_stage_if #(.W(W)) bus ();

  add_round_key_stage #(.NR(NR), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] mkey [NR+1];
  logic [3:0]   mrnd;
  logic         mv;
  int           tests;
  int           fails;

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i <= NR; i++) mkey[i] = '0;
    mrnd = '0;
    mv   = 1'b0;
  endtask

  // One clock: drive at negedge, check, update model, return at posedge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic f,
                       input logic ordy, input logic kwe = 1'b0,
                       input logic [3:0] ka = 4'd0, input logic [W-1:0] kd = '0);
    logic     acc;
    logic [3:0] r;
    exp_t     e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_first  = f;
    bus.out_ready = ordy;
    bus.key_we    = kwe;
    bus.key_addr  = ka;
    bus.key_wdata = kd;
    #1;
    tests++;
    if (bus.in_ready !== (!mv || ordy)) begin
      fails++;
      $display("FAIL in_ready: got %b want %b", bus.in_ready, (!mv || ordy));
    end
    tests++;
    if (bus.out_valid !== mv) begin
      fails++;
      $display("FAIL out_valid: got %b want %b", bus.out_valid, mv);
    end
    if (mv) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: output valid with no expected beat");
      end else if (bus.out_data !== sb[0].d || bus.out_round !== sb[0].r ||
                   bus.out_last !== sb[0].l) begin
        fails++;
        $display("FAIL beat: got data=%h round=%0d last=%b want data=%h round=%0d last=%b",
                 bus.out_data, bus.out_round, bus.out_last, sb[0].d, sb[0].r, sb[0].l);
      end
    end
    acc = v && (!mv || ordy);
    if (mv && ordy && sb.size() > 0) void'(sb.pop_front());
    if (acc) begin
      r   = f ? 4'd0 : mrnd;
      e.d = d ^ mkey[r];
      e.r = r;
      e.l = (r == 4'(NR));
      sb.push_back(e);
      mrnd = (r == 4'(NR)) ? 4'd0 : r + 4'd1;
    end
    if (kwe && ka <= 4'(NR)) mkey[ka] = kd;
    mv = acc ? 1'b1 : (ordy ? 1'b0 : mv);
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (mv && n < 20) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    tests++;
    if (mv || sb.size() != 0) begin
      fails++;
      $display("FAIL drain: timeout, %0d beats still expected", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_first = 1'b0;
    bus.out_ready = 1'b0; bus.key_we = 1'b0; bus.key_addr = '0; bus.key_wdata = '0;
    model_reset();
    #12;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_round !== 4'd0 ||
        bus.out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b data=%h round=%0d last=%b want all zero",
               bus.out_valid, bus.out_data, bus.out_round, bus.out_last);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_fips();
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    cycle(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b1);
    #2;
    tests++;
    if (bus.out_data !== 128'h00102030405060708090a0b0c0d0e0f0 ||
        bus.out_round !== 4'd0 || bus.out_last !== 1'b0 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL fips_round0: got data=%h round=%0d last=%b valid=%b want 00102030405060708090a0b0c0d0e0f0/0/0/1",
               bus.out_data, bus.out_round, bus.out_last, bus.out_valid);
    end
    drain();
  endtask

  task automatic test_block_wrap();
    for (int i = 0; i <= NR; i++)
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'(i), {16{8'(i)}});
    for (int i = 0; i <= NR; i++)
      cycle(1'b1, '0, (i == 0), 1'b1);
    cycle(1'b1, '0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    cycle(1'b1, rnd128(), 1'b1, 1'b0);
    cycle(1'b1, rnd128(), 1'b0, 1'b0);
    cycle(1'b1, rnd128(), 1'b0, 1'b0);
    cycle(1'b1, rnd128(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd128(), 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'($urandom), rnd128(), 1'b0, 1'($urandom));
    drain();
  endtask

  task automatic test_resync();
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd128(), (i == 0), 1'b1);
    cycle(1'b1, rnd128(), 1'b1, 1'b1);
    cycle(1'b1, rnd128(), 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_key_write();
    cycle(1'b1, rnd128(), 1'b1, 1'b1);
    cycle(1'b1, rnd128(), 1'b0, 1'b1);
    cycle(1'b1, rnd128(), 1'b0, 1'b1, 1'b1, 4'd2, '1);
    for (int i = 3; i <= NR; i++) cycle(1'b1, rnd128(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd128(), (i == 0), 1'b1);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd11, rnd128());
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd15, rnd128());
    for (int i = 0; i <= NR; i++) cycle(1'b1, rnd128(), (i == 0), 1'b1);
    drain();
  endtask

  task automatic test_async_reset();
    cycle(1'b1, rnd128(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_round !== 4'd0 ||
        bus.out_last !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got valid=%b data=%h round=%0d last=%b want all zero",
               bus.out_valid, bus.out_data, bus.out_round, bus.out_last);
    end
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i <= NR + 1; i++) cycle(1'b1, rnd128(), 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fips();
    test_block_wrap();
    test_backpressure();
    test_resync();
    test_key_write();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage that sits directly downstream of the MixColumns block in the AES datapath.
- XORs each incoming 128-bit state with the round key for the current round. Keys come from an internal round-key register file, loaded by the key-expansion/controller logic.
- Tracks the round index per block with an internal counter and flags the final round.
- Provides one-entry valid/ready buffering at full throughput.

Parameters:
- NR, 10, number of AES rounds; the key file holds NR+1 keys, indices 0..NR.
- W, 128, state/key width in bits; fixed at 128 for AES, exposed only for readability.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key_we  input  1  round-key write strobe.
- key_addr  input  4  round-key index to write.
- key_wdata  input  W  round-key value; byte order matches state order, [127:120] = byte 0.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  W  state from MixColumns (or the bypass path for rounds 0 and NR).
- in_first  input  1  qualifies in_valid; beat is round 0 of a new block.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  W  in_data XOR key[round].
- out_round  output  4  round index used for out_data.
- out_last  output  1  out_round == NR.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - out_valid=0, out_data=0, out_round=0, out_last=0.
  - Round counter rnd=0.
  - All NR+1 key registers = 0.
  - in_ready is 1 after reset, because it is combinational from out_valid.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational, with no dependency on in_valid.
  - accept = in_valid && in_ready.
  - On accept, out_data, out_round and out_last load on the same edge, and out_valid becomes 1.
  - If out_valid && out_ready && !accept, out_valid clears to 0. out_data, out_round and out_last hold their values.
  - Under backpressure (out_valid && !out_ready), all outputs hold stable.
- Latency and throughput: latency is 1 cycle; throughput is 1 beat per cycle with continuous out_ready.
- Round selection:
  - Effective round r = in_first ? 0 : rnd.
  - out_data = in_data ^ key[r].
  - out_round = r.
  - out_last = (r == NR).
- Counter update on accept:
  - If r == NR, rnd <= 0 (wrap).
  - Otherwise rnd <= r + 1.
  - There is no change without accept.
  - in_first mid-block aborts the current block silently and resynchronises the count to round 0. No error flag is raised.
- Key writes:
  - If key_we && key_addr <= NR, key[key_addr] <= key_wdata.
  - Writes with key_addr > NR are ignored.
  - Writes are allowed at any time.
  - A beat accepted in the same cycle as a write to its own key index uses the old key value; the new value applies from the next accepted beat.
  - Keys are not double-buffered. Rekeying mid-block is legal, and the controller owns the consequences.
- Reset mid-operation:
  - Any held output is dropped, rnd returns to 0, and keys clear.
  - The first beat after reset is treated as round 0 even when in_first=0.
- Arithmetic: pure bitwise XOR, no carries. The counter is 4 bits; NR must be ≤ 15 (elaboration check).

Test Plan:
- FIPS-197 App. C.1 round 0:
  - Stimulus: write key[0]=000102030405060708090a0b0c0d0e0f; drive in_data=00112233445566778899aabbccddeeff with in_first=1 and out_ready=1.
  - Required response: one cycle later, out_data=00102030405060708090a0b0c0d0e0f0, out_round=0, out_last=0.
- Full block and wrap:
  - Stimulus: load key[i]={16{i[7:0]}} for i=0..10; stream 11 back-to-back beats of all-zero data, first with in_first=1; then send a 12th beat with in_first=0.
  - Required response: out_data of beat i = {16{i}}; out_round runs 0..10; out_last=1 only on beat 10. The 12th beat gives out_round=0 (wrap).
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with in_valid=1.
  - Required response: in_ready=0 after the first accept, and out_data, out_round and out_last stay stable. On release, exactly one beat transfers per cycle, with no loss or duplication (compare against a scoreboard).
- Resync:
  - Stimulus: after 4 beats (rounds 0..3), assert in_first on the 5th beat.
  - Required response: the 5th beat has out_round=0; the 6th beat has out_round=1.
- Key write collision and bad address:
  - Stimulus: write key[2]=ffff…ff in the same cycle the round-2 beat is accepted.
  - Required response: that beat uses the old key[2]; the next block's round-2 beat uses ffff…ff.
  - Stimulus: write with key_addr=11 (NR=10).
  - Required response: no key register changes.
- Async reset:
  - Stimulus: assert rst_n=0 mid-cycle while out_valid=1 under backpressure.
  - Required response: out_valid, out_data and out_round go to 0 immediately, without waiting for a clock edge, and all keys read back as 0. After release, the next beat with in_first=0 reports out_round=0.
